a2d_spi_resp: RTL and testbench
===============================

// Module: a2d_spi_resp
// PURPOSE
//  SPI responder modelling the 8-channel 12-bit A2D converter on the far end of our SPI
//  monarch link (SS_n/SCLK/MOSI in, MISO out). Each 16-bit frame does two things:
//  - captures the channel command carried on MOSI;
//  - returns on MISO the conversion of the channel commanded in the PREVIOUS frame.
//  Used as the converter model in chip-level benches and as an FPGA loop-back target.
// PARAMETERS
//  NUM_CH      8   channel count; channel field is 3 bits wide
//  DATA_W      12  conversion width, right-justified in the 16-bit frame
//  SYNC_STAGES 2   flops per synchronizer on SS_n/SCLK/MOSI (>=2)
// PORTS
//  clk      in   1               system clock; SCLK is at most clk/8
//  rst      in   1               async active-high reset
//  SS_n     in   1               frame select, active low
//  SCLK     in   1               serial clock, idles high
//  MOSI     in   1               command data, monarch changes it on SCLK fall
//  ch_data  in   NUM_CH*DATA_W   channel values, ch k = ch_data[k*DATA_W +: DATA_W]
//  MISO     out  1               response data, MSB first
//  chnl     out  3               channel captured by last good frame (= rx_cmd[13:11])
//  rx_cmd   out  16              last complete frame received on MOSI
//  frm_vld  out  1               1-clk pulse: 16-bit frame completed cleanly
//  frm_err  out  1               1-clk pulse: frame ended with bit count != 16
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset values: MISO=0, chnl=0, rx_cmd=16'h0000, frm_vld=0, frm_err=0.
//  Synchronizer flops reset to idle levels: SS_n=1, SCLK=1, MOSI=0.
//  Inputs are synchronized (SYNC_STAGES). Edges are detected on synced signals against one more flop.
//  FSM states: IDLE, ARMED, SHIFT.
//  - IDLE: waits for synced SS_n=1, then goes to ARMED. After reset, a frame already in
//    progress (SS_n low) is ignored until SS_n rises.
//  - ARMED -> SHIFT on synced SS_n fall. Same clk:
//    - tx_shft <= {{(16-DATA_W){1'b0}}, ch_data[chnl*DATA_W +: DATA_W]};
//    - bit_cnt <= 0.
//    ch_data is sampled only at this point. Later changes do not affect the frame.
//  - SHIFT, on each synced SCLK rise:
//    - rx_shft <= {rx_shft[14:0], MOSI_s};
//    - tx_shft <= {tx_shft[14:0], 1'b0};
//    - bit_cnt++, saturating at 31.
//  - SHIFT, on synced SS_n rise:
//    - bit_cnt==16: rx_cmd <= rx_shft, chnl <= rx_shft[13:11], frm_vld=1 for 1 clk.
//    - otherwise: frm_err=1 for 1 clk. rx_cmd and chnl are unchanged. Aborted or overlong frame.
//    - Either way, next state is ARMED.
//  - SS_n rise and SCLK rise detected in the same clk: process the SCLK edge first, then evaluate bit_cnt.
//  MISO = tx_shft[15] in SHIFT, else 0. Bit 15 is valid before the first SCLK rise.
//  Each later bit appears SYNC_STAGES+1 clks after an SCLK rise, ahead of the next rise.
//  Back-to-back frames: the response channel is always the chnl latched at the end of the previous good frame.
//  The first frame after reset returns ch 0.
//  Bits [15:14] and [10:0] of the command are stored in rx_cmd but otherwise ignored.
//  Channel values >= NUM_CH return 0.
//  rst asserted mid-frame: everything returns to reset values. The FSM restarts in IDLE.
// TESTING
//  1 Reset, ch k data = 12'h100+k; frame cmd 16'h2000 (ch4), then frame cmd 16'h0000.
//    -> frame1 MISO=16'h0100 (ch0), chnl=4 after frame1; frame2 MISO=16'h0104.
//  2 Round-robin cmds ch0,4,5,6 repeated twice back-to-back, ch_data random.
//    -> each reply equals the prior frame's channel value; frm_vld x8, frm_err never.
//  3 SS_n raised after 9 SCLK rises, cmd bits for ch5.
//    -> frm_err pulse, chnl unchanged, next frame replies with the old channel value.
//  4 ch_data[ch4] changed from 12'hABC to 12'h123 mid-frame, after SS_n fall.
//    -> reply is 16'h0ABC; the following ch4 read returns 16'h0123.
//  5 rst pulsed after 6 SCLK rises, SS_n held low to frame end.
//    -> no frm_vld/frm_err, MISO=0 to frame end; next full frame valid and returns ch0.
//  6 17 SCLK rises in one frame -> frm_err; chnl and rx_cmd unchanged.

Source files
------------

// File: rtl/a2d_spi_resp_if.sv
// SPI link between the monarch and the A2D responder model.
// The monarch drives SS_n/SCLK/MOSI and the responder drives MISO.
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder modelling an 8-channel 12-bit A2D converter. Each 16-bit frame latches a channel
// command from MOSI and returns, on MISO, the value of the channel commanded in the previous frame.
module a2d_spi_resp #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    a2d_spi_resp_if.slave            spi,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [2:0]               chnl,
    output logic [15:0]              rx_cmd,
    output logic                     frm_vld,
    output logic                     frm_err,
    output logic [1:0]               state_dbg
);
    // Frame results are one-clock pulses with no back-pressure:
    // frm_vld means rx_cmd/chnl took a new value on that clock; frm_err means the frame was discarded.
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync, fill;
    logic                   ss_d, sclk_d;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise;

    logic [15:0] tx_shft, tx_d;
    logic [15:0] rx_shft, rx_d;
    logic [4:0]  bit_cnt, cnt_d;
    logic        vld_d, err_d;
    logic [DATA_W-1:0] ch_sel;

    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign sclk_rise = ~sclk_d & sclk_s;

    // fill marks when the synchronizers hold real samples rather than their reset levels,
    // so a frame already in progress at reset is not mistaken for a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            ss_d      <= 1'b1;
            sclk_d    <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            ss_d      <= ss_s;
            sclk_d    <= sclk_s;
        end
    end

    // Unpopulated channel numbers read as zero.
    always_comb begin
        ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (chnl == 3'(k)) ch_sel = ch_data[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_shft;
        rx_d    = rx_shft;
        cnt_d   = bit_cnt;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill[SYNC_STAGES-1] && ss_s) state_d = ARMED;
            end
            ARMED: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    tx_d    = {{(16-DATA_W){1'b0}}, ch_sel};
                    cnt_d   = 5'd0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_d  = {rx_shft[14:0], mosi_s};
                    tx_d  = {tx_shft[14:0], 1'b0};
                    cnt_d = (bit_cnt == 5'd31) ? 5'd31 : bit_cnt + 5'd1;
                end
                // A simultaneous SCLK rise is already folded into cnt_d/rx_d here.
                if (ss_rise) begin
                    state_d = ARMED;
                    if (cnt_d == 5'd16) vld_d = 1'b1;
                    else                err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tx_shft <= '0;
            rx_shft <= '0;
            bit_cnt <= '0;
            rx_cmd  <= '0;
            chnl    <= '0;
            frm_vld <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_shft <= tx_d;
            rx_shft <= rx_d;
            bit_cnt <= cnt_d;
            frm_vld <= vld_d;
            frm_err <= err_d;
            if (vld_d) begin
                rx_cmd <= rx_d;
                chnl   <= rx_d[13:11];
            end
        end
    end

    assign spi.MISO  = (state_q == SHIFT) ? tx_shft[15] : 1'b0;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: directed frame table, hand-written corner sequences,
// then randomized frames scored against a frame-level model of the converter.
module tb_a2d_spi_resp;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 12;

    logic                     clk;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [2:0]               chnl;
    logic [15:0]              rx_cmd;
    logic                     frm_vld;
    logic                     frm_err;
    logic [1:0]               state_dbg;

    a2d_spi_resp_if spi ();

    a2d_spi_resp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi.slave),
        .ch_data   (ch_data),
        .chnl      (chnl),
        .rx_cmd    (rx_cmd),
        .frm_vld   (frm_vld),
        .frm_err   (frm_err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ch_arr [NUM_CH];
    always_comb begin
        ch_data = '0;
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch_arr[k];
    end

    int vld_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (frm_vld) vld_cnt++;
        if (frm_err) err_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q [$];

    logic              chg_en = 1'b0;
    int                chg_idx = 0;
    logic [DATA_W-1:0] chg_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: one SPI frame, SCLK = clk/10, MOSI changes on SCLK fall, MISO sampled before each rise
    task automatic run_frame(input logic [15:0] cmd, input int n_rise, input int rst_after,
                             output logic [15:0] miso_w);
        logic [15:0] sh;
        sh     = cmd;
        miso_w = '0;
        spi.SS_n = 1'b0;
        repeat (6) @(negedge clk);
        if (chg_en) begin
            ch_arr[chg_idx] = chg_val;
            chg_en = 1'b0;
        end
        for (int i = 0; i < n_rise; i++) begin
            spi.SCLK = 1'b0;
            spi.MOSI = sh[15];
            sh = sh << 1;
            repeat (5) @(negedge clk);
            if (i < 16) miso_w = {miso_w[14:0], spi.MISO};
            spi.SCLK = 1'b1;
            repeat (5) @(negedge clk);
            if (i + 1 == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        if (n_rise < 16) miso_w = miso_w << (16 - n_rise);
        repeat (5) @(negedge clk);
        spi.SS_n = 1'b1;
        spi.MOSI = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_check(input string name, input logic [15:0] cmd, input int n_rise,
                               input int rst_after, input logic chk_miso, input logic [15:0] reply,
                               input int e_vld, input int e_err, input logic [2:0] e_chnl,
                               input logic [15:0] e_rx);
        logic [15:0] got;
        int v0, e0;
        v0 = vld_cnt;
        e0 = err_cnt;
        run_frame(cmd, n_rise, rst_after, got);
        if (chk_miso) check({name, " miso"}, 32'(got), 32'(reply));
        check({name, " frm_vld"}, 32'(vld_cnt - v0), 32'(e_vld));
        check({name, " frm_err"}, 32'(err_cnt - e0), 32'(e_err));
        check({name, " chnl"}, 32'(chnl), 32'(e_chnl));
        check({name, " rx_cmd"}, 32'(rx_cmd), 32'(e_rx));
    endtask

    typedef struct {
        logic [15:0] cmd;
        int          n_rise;
        logic        chk_miso;
        logic [15:0] reply;
        int          vld;
        int          err;
        logic [2:0]  chnl;
        logic [15:0] rx;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [15:0] got;
        logic [15:0] cmd;
        logic [15:0] exp_reply;
        logic [15:0] rr_cmd [4];
        int          n;
        int          v0, e0;
        logic [2:0]  m_chnl;
        logic [15:0] m_rx;

        vecs[0]  = '{16'h2000, 16, 1'b1, 16'h0100, 1, 0, 3'd4, 16'h2000};
        vecs[1]  = '{16'h0000, 16, 1'b1, 16'h0104, 1, 0, 3'd0, 16'h0000};
        vecs[2]  = '{16'h2800,  9, 1'b0, 16'h0000, 0, 1, 3'd0, 16'h0000};
        vecs[3]  = '{16'h1800, 16, 1'b1, 16'h0100, 1, 0, 3'd3, 16'h1800};
        vecs[4]  = '{16'h2000, 17, 1'b1, 16'h0103, 0, 1, 3'd3, 16'h1800};
        vecs[5]  = '{16'hC7FF, 16, 1'b1, 16'h0103, 1, 0, 3'd0, 16'hC7FF};
        vecs[6]  = '{16'h3800, 16, 1'b1, 16'h0100, 1, 0, 3'd7, 16'h3800};
        vecs[7]  = '{16'h0000, 16, 1'b1, 16'h0107, 1, 0, 3'd0, 16'h0000};
        vecs[8]  = '{16'h0000,  0, 1'b0, 16'h0000, 0, 1, 3'd0, 16'h0000};
        vecs[9]  = '{16'h0800, 16, 1'b1, 16'h0100, 1, 0, 3'd1, 16'h0800};
        vecs[10] = '{16'h2000, 15, 1'b0, 16'h0000, 0, 1, 3'd1, 16'h0800};
        vecs[11] = '{16'h0000, 16, 1'b1, 16'h0101, 1, 0, 3'd0, 16'h0000};

        rst = 1'b1;
        spi.SS_n = 1'b1;
        spi.SCLK = 1'b1;
        spi.MOSI = 1'b0;
        for (int k = 0; k < NUM_CH; k++) ch_arr[k] = 12'h100 + 12'(k);
        repeat (3) @(negedge clk);
        check("reset MISO", 32'(spi.MISO), 32'd0);
        check("reset chnl", 32'(chnl), 32'd0);
        check("reset rx_cmd", 32'(rx_cmd), 32'd0);
        check("reset frm_vld", 32'(frm_vld), 32'd0);
        check("reset frm_err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 12; i++)
            frame_check($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].n_rise, -1, vecs[i].chk_miso,
                        vecs[i].reply, vecs[i].vld, vecs[i].err, vecs[i].chnl, vecs[i].rx);

        // ch_data sampled only at frame start
        ch_arr[4] = 12'hABC;
        frame_check("snap_a", 16'h2000, 16, -1, 1'b1, 16'h0100, 1, 0, 3'd4, 16'h2000);
        chg_en = 1'b1; chg_idx = 4; chg_val = 12'h123;
        frame_check("snap_b", 16'h2000, 16, -1, 1'b1, 16'h0ABC, 1, 0, 3'd4, 16'h2000);
        frame_check("snap_c", 16'h0000, 16, -1, 1'b1, 16'h0123, 1, 0, 3'd0, 16'h0000);

        // reset in the middle of a frame
        frame_check("pre_rst", 16'h2800, 16, -1, 1'b1, 16'h0100, 1, 0, 3'd5, 16'h2800);
        frame_check("mid_rst", 16'h2000, 16,  6, 1'b1, 16'h0000, 0, 0, 3'd0, 16'h0000);
        frame_check("post_rst", 16'h1000, 16, -1, 1'b1, 16'h0100, 1, 0, 3'd2, 16'h1000);

        // randomized frames against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        m_chnl = 3'd0;
        m_rx   = 16'h0000;
        rr_cmd[0] = 16'h0000; rr_cmd[1] = 16'h2000; rr_cmd[2] = 16'h2800; rr_cmd[3] = 16'h3000;
        for (int f = 0; f < 28; f++) begin
            for (int k = 0; k < NUM_CH; k++) ch_arr[k] = 12'($urandom_range(0, 4095));
            if (f < 8) begin
                cmd = rr_cmd[f % 4];
                n   = 16;
            end else begin
                cmd = 16'($urandom_range(0, 65535));
                n   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16;
            end
            exp_q.push_back({4'h0, ch_arr[m_chnl]});
            v0 = vld_cnt;
            e0 = err_cnt;
            run_frame(cmd, n, -1, got);
            exp_reply = exp_q.pop_front();
            if (n >= 16) check($sformatf("rnd%0d miso", f), 32'(got), 32'(exp_reply));
            if (n == 16) begin
                m_rx   = cmd;
                m_chnl = cmd[13:11];
            end
            check($sformatf("rnd%0d frm_vld", f), 32'(vld_cnt - v0), (n == 16) ? 32'd1 : 32'd0);
            check($sformatf("rnd%0d frm_err", f), 32'(err_cnt - e0), (n == 16) ? 32'd0 : 32'd1);
            check($sformatf("rnd%0d chnl", f), 32'(chnl), 32'(m_chnl));
            check($sformatf("rnd%0d rx_cmd", f), 32'(rx_cmd), 32'(m_rx));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
